ft_recovery_unit: RTL and testbench
===================================

Name: ft_recovery_unit

Overview:
- Parametrised fault-tolerance controller for 2 (DMR) or 3 (TMR) lockstepped cores.
- Compares register-file writeback and PC of all cores every cycle, and commits agreed results into an internal shadow register file and shadow PC.
- On a detected fault, halts and resets the cores, replays the shadow register file and resumes them.
- A bounded retry counter escalates repeated faults to a sticky fail state.

Parameters:
ADDR_WIDTH, 5, register index width; shadow file depth is 2**ADDR_WIDTH.
DATA_WIDTH, 32, register/PC width.
NUM_CORES, 3, lockstepped cores; legal values 2 (detect only) or 3 (majority vote).
MAX_RETRIES, 3, recoveries allowed before fail; legal range 1..15.
CLEAN_CYCLES, 16, consecutive clean RUN cycles that clear the retry counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
we_i  in  NUM_CORES  per-core writeback enable.
addr_i  in  NUM_CORES*ADDR_WIDTH  per-core writeback index; core k occupies slice k.
data_i  in  NUM_CORES*DATA_WIDTH  per-core writeback data.
spc_i  in  NUM_CORES*DATA_WIDTH  per-core current PC.
halted_i  in  NUM_CORES  core reports halted.
halt_o  out  1  halt request to all cores.
reset_o  out  1  one-cycle core reset pulse.
resume_o  out  1  one-cycle resume pulse.
replay_valid_o  out  1  addr_o/data_o carry a replay write.
addr_o  out  ADDR_WIDTH  replay register index.
data_o  out  DATA_WIDTH  replay register data.
spc_o  out  DATA_WIDTH  shadow PC for restart.
fault_core_o  out  NUM_CORES  sticky per-core TMR fault flags.
error_count_o  out  8  saturating total-fault counter.
fail_o  out  1  sticky unrecoverable-fault flag.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Shadow file and shadow PC cleared to 0. State RUN. Retry, clean and replay counters cleared.
- Core tuple k = {we, addr, data}. When we=0, addr and data are don't-care for tuple equality. Pair match = equal tuples AND equal spc.
- NUM_CORES=2: error = pair mismatch. Commit only when no error.
- NUM_CORES=3 (majority):
  - All three match: no error, commit.
  - Exactly one outlier: commit the majority tuple, error=1, set fault_core_o[outlier].
  - No two match: error=1, no commit, no fault_core bit set.
- Commit (RUN only):
  - If committed we=1 and addr!=0, write shadow[addr] at the clock edge.
  - Index 0 always reads 0.
  - Shadow PC loads committed spc every commit cycle.
- FSM:
  - RUN: error → if retry_cnt==MAX_RETRIES go FAIL, else retry_cnt++, error_count++ (saturates at 255), go HALT. No error: clean_cnt++; at CLEAN_CYCLES, retry_cnt←0 and clean_cnt←0. Any error clears clean_cnt.
  - HALT: halt_o=1. Stay until halted_i is all ones, then go RESET.
  - RESET: reset_o=1 for exactly one cycle, halt_o=1, replay counter←0, go REPLAY.
  - REPLAY: replay_valid_o=1, halt_o=1. addr_o=counter, data_o=shadow[counter] combinationally in the same cycle. Counter increments each cycle. After index 2**ADDR_WIDTH-1 go RESUME. Length is exactly 2**ADDR_WIDTH cycles.
  - RESUME: resume_o=1 for one cycle, halt_o=0, go RUN.
  - FAIL: halt_o=1 and fail_o=1, both sticky until rst_n.
- spc_o continuously shows the shadow PC; it is frozen outside RUN.
- Comparator errors are ignored outside RUN; no commits occur outside RUN.
- Outside REPLAY: addr_o=0, data_o=0.
- Commit and error detection in the same cycle (TMR single outlier): the write lands, and the FSM enters HALT the next cycle.
- A fault on the final retry goes to FAIL, not HALT, and error_count still increments.
- rst_n asserted mid-recovery aborts immediately to RUN with a cleared shadow state.

Test Plan:
- TMR, all cores write addr 5 = 0xDEADBEEF → shadow[5] updated. Force a fault, complete the replay, and check cycle 5 of REPLAY shows addr_o=5, data_o=0xDEADBEEF; no error.
- TMR, core 1 writes 0x1 while cores 0/2 write 0x2 to addr 3 → shadow[3]=0x2, fault_core_o=3'b010, HALT next cycle. Hold halted_i=3'b111 → reset_o pulse, then 32 replay cycles, then resume_o pulse.
- DMR, data mismatch 0xA vs 0xB at addr 7 → no commit, shadow[7] unchanged, error_count_o=1.
- TMR, three distinct writes → no commit, fault_core_o unchanged, recovery starts.
- Four consecutive faults with MAX_RETRIES=3 and fewer than 16 clean cycles between them → fourth fault gives fail_o=1, halt_o stuck at 1, error_count_o=4.
- Fault, then 16 clean RUN cycles, then three more faults → all recover with no fail. Assert rst_n=0 during REPLAY → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ft_recovery_unit.sv
// ft_recovery_unit: lockstep checker and recovery sequencer for 2 (DMR) or
// 3 (TMR) cores. Agreed writebacks are mirrored into a shadow register file
// and shadow PC; a detected fault halts the cores, pulses their reset,
// replays the shadow file and resumes them. Repeated faults escalate to a
// sticky fail state.
module ft_recovery_unit #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CORES    = 3,
  parameter int MAX_RETRIES  = 3,
  parameter int CLEAN_CYCLES = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] spc_i,
  input  logic [NUM_CORES-1:0]            halted_i,
  output logic                            halt_o,
  output logic                            reset_o,
  output logic                            resume_o,
  output logic                            replay_valid_o,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [DATA_WIDTH-1:0]           spc_o,
  output logic [NUM_CORES-1:0]            fault_core_o,
  output logic [7:0]                      error_count_o,
  output logic                            fail_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int KW    = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;  // {we, addr, data, spc}
  localparam int CW    = $clog2(CLEAN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN, S_HALT, S_RESET, S_REPLAY, S_RESUME, S_FAIL
  } state_t;

  state_t                  r_state, w_next;
  logic [DATA_WIDTH-1:0]   r_shadow [DEPTH];
  logic [DATA_WIDTH-1:0]   r_spc;
  logic [3:0]              r_retry;
  logic [CW-1:0]           r_clean;
  logic [7:0]              r_err_cnt;
  logic [NUM_CORES-1:0]    r_fault;
  logic [ADDR_WIDTH-1:0]   r_rcnt;

  logic [KW-1:0]           w_key [NUM_CORES];
  logic [KW-1:0]           w_ckey;
  logic                    w_err, w_commit, w_run;
  logic [NUM_CORES-1:0]    w_outlier;
  logic                    w_c_we;
  logic [ADDR_WIDTH-1:0]   w_c_addr;
  logic [DATA_WIDTH-1:0]   w_c_data, w_c_spc;

  // Canonical per-core key: address and data are zeroed when we=0 so that a
  // plain equality compare treats them as don't-care.
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_key
    assign w_key[k] = we_i[k]
      ? {1'b1, addr_i[k*ADDR_WIDTH +: ADDR_WIDTH], data_i[k*DATA_WIDTH +: DATA_WIDTH],
         spc_i[k*DATA_WIDTH +: DATA_WIDTH]}
      : {1'b0, {ADDR_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, spc_i[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  if (NUM_CORES == 3) begin : g_tmr
    logic w_m01, w_m02, w_m12;
    assign w_m01 = (w_key[0] == w_key[1]);
    assign w_m02 = (w_key[0] == w_key[2]);
    assign w_m12 = (w_key[1] == w_key[2]);

    // Majority vote: pick the agreed tuple and flag the single dissenter.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
      w_err     = 1'b1;
      w_commit  = 1'b0;
      w_ckey    = w_key[0];
      w_outlier = '0;
      if (w_m01 && w_m02) begin
        w_err    = 1'b0;
        w_commit = 1'b1;
      end else if (w_m01) begin
        w_commit  = 1'b1;
        w_outlier = 3'b100;
      end else if (w_m02) begin
        w_commit  = 1'b1;
        w_outlier = 3'b010;
      end else if (w_m12) begin
        w_commit  = 1'b1;
        w_ckey    = w_key[1];
        w_outlier = 3'b001;
      end
    end
  end else begin : g_dmr
    // Pair compare: detection only, no vote and no per-core blame.
    always_comb begin
      w_err     = (w_key[0] != w_key[1]);
      w_commit  = ~w_err;
      w_ckey    = w_key[0];
      w_outlier = '0;
    end
  end

  assign w_c_we   = w_ckey[KW-1];
  assign w_c_addr = w_ckey[KW-2 -: ADDR_WIDTH];
  assign w_c_data = w_ckey[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign w_c_spc  = w_ckey[DATA_WIDTH-1:0];
  assign w_run    = (r_state == S_RUN);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  end

  // Next-state and Moore outputs of the recovery sequencer.
  always_comb begin
    w_next         = r_state;
    halt_o         = 1'b0;
    reset_o        = 1'b0;
    resume_o       = 1'b0;
    replay_valid_o = 1'b0;
    addr_o         = '0;
    data_o         = '0;
    fail_o         = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_err) w_next = (r_retry == 4'(MAX_RETRIES)) ? S_FAIL : S_HALT;
      end
      S_HALT: begin
        halt_o = 1'b1;
        if (&halted_i) w_next = S_RESET;
      end
      S_RESET: begin
        halt_o  = 1'b1;
        reset_o = 1'b1;
        w_next  = S_REPLAY;
      end
      S_REPLAY: begin
        halt_o         = 1'b1;
        replay_valid_o = 1'b1;
        addr_o         = r_rcnt;
        data_o         = r_shadow[r_rcnt];
        if (r_rcnt == {ADDR_WIDTH{1'b1}}) w_next = S_RESUME;
      end
      S_RESUME: begin
        resume_o = 1'b1;
        w_next   = S_RUN;
      end
      S_FAIL: begin
        halt_o = 1'b1;
        fail_o = 1'b1;
      end
      default: w_next = S_RUN;
    endcase
  end

  // Retry/clean/error bookkeeping and sticky per-core blame, RUN only.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_retry   <= '0;
      r_clean   <= '0;
      r_err_cnt <= '0;
      r_fault   <= '0;
    end else if (w_run) begin
      if (w_err) begin
        r_clean <= '0;
        r_fault <= r_fault | w_outlier;
        if (r_retry != 4'(MAX_RETRIES)) r_retry <= r_retry + 4'd1;
        if (r_err_cnt != 8'hFF)         r_err_cnt <= r_err_cnt + 8'd1;
      end else if (r_clean == CW'(CLEAN_CYCLES - 1)) begin
        r_clean <= '0;
        r_retry <= '0;
      end else begin
        r_clean <= r_clean + CW'(1);
      end
    end
  end

  // Replay index: cleared while the cores are held in reset, then walks the file.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                    r_rcnt <= '0;
    else if (r_state == S_RESET)   r_rcnt <= '0;
    else if (r_state == S_REPLAY)  r_rcnt <= r_rcnt + ADDR_WIDTH'(1);
  end

  // Shadow register file and PC: updated only by committed RUN cycles.
  // NOTE: the shadow file is explicitly cleared on reset because the replay
  // path reads every entry, including ones never written since reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
      r_spc <= '0;
    end else if (w_run && w_commit) begin
      r_spc <= w_c_spc;
      if (w_c_we && (w_c_addr != '0)) r_shadow[w_c_addr] <= w_c_data;
    end
  end

  assign spc_o         = r_spc;
  assign fault_core_o  = r_fault;
  assign error_count_o = r_err_cnt;

endmodule

// File: tb/tb_ft_recovery_unit.sv
// Bench for ft_recovery_unit: a TMR instance checked against a behavioural
// vote/shadow model under random and directed traffic, plus a small DMR
// instance exercised with directed steps.
module tb_ft_recovery_unit;
  localparam int AW = 5, DW = 32, MAXR = 3, CLEAN = 16, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // TMR instance
  logic [2:0]  we, halted;
  logic [14:0] addr;
  logic [95:0] data, spc;
  logic halt, rst_o, resume, rv, fail;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o, spc_o;
  logic [2:0] fault;
  logic [7:0] ecnt;

  // DMR instance
  logic [1:0]  d_we, d_halted;
  logic [9:0]  d_addr;
  logic [63:0] d_data, d_spc;
  logic d_halt, d_rst_o, d_resume, d_rv, d_fail;
  logic [AW-1:0] d_addr_o;
  logic [DW-1:0] d_data_o, d_spc_o;
  logic [1:0] d_fault;
  logic [7:0] d_ecnt;

  ft_recovery_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(3),
                     .MAX_RETRIES(MAXR), .CLEAN_CYCLES(CLEAN)) u_dut (
    .clk_i(clk), .rst_n(rst_n), .we_i(we), .addr_i(addr), .data_i(data),
    .spc_i(spc), .halted_i(halted), .halt_o(halt), .reset_o(rst_o),
    .resume_o(resume), .replay_valid_o(rv), .addr_o(addr_o), .data_o(data_o),
    .spc_o(spc_o), .fault_core_o(fault), .error_count_o(ecnt), .fail_o(fail));

  ft_recovery_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(2),
                     .MAX_RETRIES(MAXR), .CLEAN_CYCLES(CLEAN)) u_dmr (
    .clk_i(clk), .rst_n(rst_n), .we_i(d_we), .addr_i(d_addr), .data_i(d_data),
    .spc_i(d_spc), .halted_i(d_halted), .halt_o(d_halt), .reset_o(d_rst_o),
    .resume_o(d_resume), .replay_valid_o(d_rv), .addr_o(d_addr_o),
    .data_o(d_data_o), .spc_o(d_spc_o), .fault_core_o(d_fault),
    .error_count_o(d_ecnt), .fail_o(d_fail));

  int total = 0, bad = 0;

  // Reference model state
  logic [DW-1:0] m_shadow [DEPTH];
  logic [DW-1:0] m_pc;
  int            m_retry, m_clean, m_err;
  logic [2:0]    m_fault;
  bit            m_fail;

  // Per-core stimulus as presented to the TMR instance
  bit            c_we   [3];
  logic [AW-1:0] c_addr [3];
  logic [DW-1:0] c_data [3];
  logic [DW-1:0] c_spc  [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 3; k++) begin
      we[k]             = c_we[k];
      addr[k*AW +: AW]  = c_addr[k];
      data[k*DW +: DW]  = c_data[k];
      spc[k*DW +: DW]   = c_spc[k];
    end
  endtask

  task automatic set_agree(input int w, input int a, input logic [DW-1:0] d, input logic [DW-1:0] p);
    for (int k = 0; k < 3; k++) begin
      c_we[k]  = (w != 0);
      c_spc[k] = p;
      c_addr[k] = (w != 0) ? AW'(a) : AW'($urandom_range(0, 31));
      c_data[k] = (w != 0) ? d : $urandom;
    end
    pack();
  endtask

  task automatic set_idle();
    set_agree(0, 0, 0, $urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_shadow[i] = '0;
    m_pc = '0; m_retry = 0; m_clean = 0; m_err = 0; m_fault = '0; m_fail = 0;
  endtask

  function automatic bit same(input int i, input int j);
    return (c_spc[i] == c_spc[j]) && (c_we[i] == c_we[j]) &&
           (!c_we[i] || (c_addr[i] == c_addr[j] && c_data[i] == c_data[j]));
  endfunction

  // One RUN (or FAIL) cycle: vote on the presented tuples, advance the clock,
  // update the model and compare.
  task automatic cycle(input string tag);
    int votes [3];
    int win, outl;
    bit err;
    win = -1; outl = -1;
    for (int i = 0; i < 3; i++) begin
      votes[i] = 0;
      for (int j = 0; j < 3; j++) if (same(i, j)) votes[i]++;
    end
    for (int i = 0; i < 3; i++) if (votes[i] >= 2 && win < 0) win = i;
    err = (votes[0] != 3);
    if (win >= 0 && err)
      for (int i = 0; i < 3; i++) if (votes[i] == 1) outl = i;
    @(posedge clk); #1;
    if (!m_fail) begin
      if (win >= 0) begin
        m_pc = c_spc[win];
        if (c_we[win] && c_addr[win] != 0) m_shadow[c_addr[win]] = c_data[win];
      end
      if (err) begin
        m_clean = 0;
        if (outl >= 0) m_fault[outl] = 1'b1;
        if (m_err < 255) m_err++;
        if (m_retry == MAXR) m_fail = 1; else m_retry++;
      end else begin
        m_clean++;
        if (m_clean == CLEAN) begin m_clean = 0; m_retry = 0; end
      end
    end
    chk({tag, ".spc"},   64'(spc_o), 64'(m_pc));
    chk({tag, ".fault"}, 64'(fault), 64'(m_fault));
    chk({tag, ".ecnt"},  64'(ecnt),  64'(m_err));
    chk({tag, ".halt"},  64'(halt),  64'(m_fail || err));
    chk({tag, ".fail"},  64'(fail),  64'(m_fail));
    chk({tag, ".rv"},    64'(rv),    64'd0);
  endtask

  task automatic clean_cycle(input string tag);
    set_agree(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom, $urandom);
    cycle(tag);
  endtask

  // Single-outlier fault on a random core, varying data, PC or write enable.
  task automatic rand_fault(input string tag);
    int k, kind;
    set_agree(1, int'($urandom_range(0, 31)), $urandom, $urandom);
    k = int'($urandom_range(0, 2));
    kind = int'($urandom_range(0, 2));
    case (kind)
      0:       c_data[k] = c_data[k] ^ ($urandom | 32'h1);
      1:       c_spc[k]  = c_spc[k] ^ 32'h4;
      default: c_we[k]   = 1'b0;
    endcase
    pack();
    cycle(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".halt"},   64'(halt),   0);
    chk({tag, ".reset"},  64'(rst_o),  0);
    chk({tag, ".resume"}, 64'(resume), 0);
    chk({tag, ".rv"},     64'(rv),     0);
    chk({tag, ".addr"},   64'(addr_o), 0);
    chk({tag, ".data"},   64'(data_o), 0);
    chk({tag, ".spc"},    64'(spc_o),  0);
    chk({tag, ".fault"},  64'(fault),  0);
    chk({tag, ".ecnt"},   64'(ecnt),   0);
    chk({tag, ".fail"},   64'(fail),   0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    halted = '0;
    set_idle();
    #1;
    chk_zero(tag);
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  // Walk a full recovery from HALT; abort_at >= 0 asserts rst_n at that
  // replay index instead of finishing.
  task automatic recover(input string tag, input int abort_at);
    for (int k = 0; k < 3; k++) begin
      c_we[k] = 1'b1; c_addr[k] = AW'($urandom_range(1, 31));
      c_data[k] = $urandom + DW'(k); c_spc[k] = $urandom;
    end
    pack();
    halted = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk({tag, ".hold_halt"},  64'(halt),  1);
      chk({tag, ".hold_reset"}, 64'(rst_o), 0);
      chk({tag, ".hold_ecnt"},  64'(ecnt),  64'(m_err));
      chk({tag, ".hold_fault"}, 64'(fault), 64'(m_fault));
    end
    halted = 3'b111;
    @(posedge clk); #1;
    chk({tag, ".reset"},      64'(rst_o), 1);
    chk({tag, ".reset_halt"}, 64'(halt),  1);
    chk({tag, ".reset_rv"},   64'(rv),    0);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      chk({tag, ".rp_valid"}, 64'(rv),     1);
      chk({tag, ".rp_addr"},  64'(addr_o), 64'(i));
      chk({tag, ".rp_data"},  64'(data_o), 64'(m_shadow[i]));
      chk({tag, ".rp_reset"}, 64'(rst_o),  0);
      chk({tag, ".rp_halt"},  64'(halt),   1);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero({tag, ".abort"});
        model_reset();
        halted = '0;
        set_idle();
        @(posedge clk); #3;
        rst_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    chk({tag, ".resume"},   64'(resume), 1);
    chk({tag, ".res_halt"}, 64'(halt),   0);
    chk({tag, ".res_rv"},   64'(rv),     0);
    chk({tag, ".res_addr"}, 64'(addr_o), 0);
    chk({tag, ".res_data"}, 64'(data_o), 0);
    @(posedge clk); #1;
    chk({tag, ".run_resume"}, 64'(resume), 0);
    chk({tag, ".run_spc"},    64'(spc_o),  64'(m_pc));
    halted = '0;
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    d_we = '0; d_addr = '0; d_data = '0; d_spc = '0; d_halted = '0;
    do_reset("rst0");
    chk("rst0.dmr_halt", 64'(d_halt), 0);
    chk("rst0.dmr_ecnt", 64'(d_ecnt), 0);

    // Agreed write to addr 5, then a single-outlier fault on core 1.
    set_agree(1, 5, 32'hDEADBEEF, 32'h100);
    cycle("w5");
    set_agree(1, 3, 32'h2, 32'h104);
    c_data[1] = 32'h1;
    pack();
    cycle("out1");
    chk("out1.fault_const", 64'(fault), 64'h2);
    chk("out1.shadow3", 64'(m_shadow[3]), 64'h2);
    recover("rec1", -1);

    repeat (20) clean_cycle("clean_a");

    // Four faults with short clean gaps: the fourth one fails.
    do_reset("rst1");
    set_agree(1, 9, 32'h11, 32'h200);
    c_data[1] = 32'h22; c_data[2] = 32'h33;
    pack();
    cycle("dist");
    chk("dist.fault_none", 64'(fault), 0);
    recover("rec_dist", -1);
    for (int f = 0; f < 2; f++) begin
      repeat (3) clean_cycle("gap");
      rand_fault("rf");
      recover("rec_rf", -1);
    end
    repeat (3) clean_cycle("gap4");
    rand_fault("rf4");
    chk("rf4.fail_const", 64'(fail), 1);
    chk("rf4.ecnt_const", 64'(ecnt), 4);
    repeat (4) clean_cycle("failhold");
    chk("failhold.halt", 64'(halt), 1);

    // Fault, 16 clean cycles clear the retry budget, then three more faults.
    do_reset("rst2");
    rand_fault("pre");
    recover("rec_pre", -1);
    repeat (CLEAN) clean_cycle("clean_b");
    for (int f = 0; f < 3; f++) begin
      rand_fault("rb");
      chk("rb.no_fail", 64'(fail), 0);
      if (f < 2) begin
        recover("rec_rb", -1);
        repeat (2) clean_cycle("gap_b");
      end else begin
        recover("rec_abort", 10);
      end
    end

    // After the aborted recovery the shadow state must be cleared.
    repeat (3) clean_cycle("post");
    rand_fault("post_f");
    recover("rec_post", -1);

    // DMR: agreed write to addr 7, then a data mismatch on the same index.
    d_we = 2'b11; d_addr = {5'd7, 5'd7};
    d_data = {32'h55, 32'h55}; d_spc = {32'h40, 32'h40};
    @(posedge clk); #1;
    chk("dmr_w.spc",  64'(d_spc_o), 64'h40);
    chk("dmr_w.halt", 64'(d_halt),  0);
    d_data = {32'hB, 32'hA}; d_spc = {32'h44, 32'h44};
    @(posedge clk); #1;
    chk("dmr_mm.ecnt",  64'(d_ecnt),  1);
    chk("dmr_mm.halt",  64'(d_halt),  1);
    chk("dmr_mm.spc",   64'(d_spc_o), 64'h40);
    chk("dmr_mm.fault", 64'(d_fault), 0);
    d_we = '0; d_halted = 2'b11;
    @(posedge clk); #1;
    chk("dmr.reset", 64'(d_rst_o), 1);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      chk("dmr.rp_addr", 64'(d_addr_o), 64'(i));
      chk("dmr.rp_data", 64'(d_data_o), (i == 7) ? 64'h55 : 64'h0);
    end
    @(posedge clk); #1;
    chk("dmr.resume", 64'(d_resume), 1);
    chk("dmr.fail",   64'(d_fail),   0);
    chk("dmr.rv",     64'(d_rv),     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
